fibonacci_checker: RTL and testbench

Streaming consumer that verifies an incoming sequence of unsigned terms is a Fibonacci series of fixed length. It is the receiving end of the team's Fibonacci series generator. It accepts terms over a valid/ready handshake, compares each term against the sum of the previous two, and reports pass/fail, the index of the first bad term and arithmetic overflow. It sits between a sequence source and the scoreboard/status logic.

---
 rtl/fibonacci_checker.sv | 132 +++++++++++++
 tb/tb_fibonacci_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_checker.sv
// fibonacci_checker: streaming consumer that checks an incoming series of
// LEN unsigned W-bit terms against the Fibonacci rule. It reports pass/fail,
// the index of the first bad term, and whether an expected sum overflowed.
// Optional feature: define FIB_CHK_SEED_EN to accept terms 0 and 1 as
// unchecked seeds, which allows generalised series such as Lucas.
module fibonacci_checker #(
   parameter int unsigned W   = 32,
   parameter int unsigned LEN = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [7:0]   err_idx,
   output logic         ovf,
   output logic [7:0]   count
);

   localparam int unsigned CW     = 8;
   localparam logic [CW-1:0] LEN_C  = CW'(LEN);
   localparam logic [CW-1:0] NO_ERR = 8'hFF;

   typedef enum logic [2:0] {IDLE, T0, T1, CHECK, DONE} state_t;

   state_t        state, state_n;
   logic [W-1:0]  p1, p2, p1_n, p2_n;
   logic [CW-1:0] count_n, err_idx_n, count_inc_c;
   logic          pass_n, ovf_n;
   logic          xfer_c, mism_c, seed_bad_c;
   logic [W:0]    exp_c;

   assign xfer_c      = in_valid && in_ready;
   assign exp_c       = {1'b0, p1} + {1'b0, p2};
   assign count_inc_c = CW'(count + 8'd1);

   // Seed terms are either unchecked or must both be exactly 1.
`ifdef FIB_CHK_SEED_EN
   assign seed_bad_c = 1'b0;
`else
   assign seed_bad_c = (in_data != W'(1));
`endif

   // Next-state and datapath update; a mismatch never aborts the series.
   always_comb begin
      state_n   = state;
      p1_n      = p1;
      p2_n      = p2;
      count_n   = count;
      pass_n    = pass;
      err_idx_n = err_idx;
      ovf_n     = ovf;
      mism_c    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n   = T0;
               count_n   = '0;
               pass_n    = 1'b1;
               err_idx_n = NO_ERR;
               ovf_n     = 1'b0;
            end
         end
         T0: begin
            if (xfer_c) begin
               p2_n    = in_data;
               mism_c  = seed_bad_c;
               count_n = count_inc_c;
               state_n = T1;
            end
         end
         T1: begin
            if (xfer_c) begin
               p1_n    = in_data;
               mism_c  = seed_bad_c;
               count_n = count_inc_c;
               state_n = (LEN_C == 8'd2) ? DONE : CHECK;
            end
         end
         CHECK: begin
            if (xfer_c) begin
               // Overflowed sums can never equal a W-bit term, so they mismatch.
               if (exp_c[W]) ovf_n = 1'b1;
               mism_c  = (exp_c != {1'b0, in_data});
               // Shift the received term so later terms follow the real stream.
               p2_n    = p1;
               p1_n    = in_data;
               count_n = count_inc_c;
               if (count_inc_c == LEN_C) state_n = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (mism_c) begin
         pass_n = 1'b0;
         if (err_idx == NO_ERR) err_idx_n = count;
      end
   end

   // State, datapath and registered handshake/status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         p1       <= '0;
         p2       <= '0;
         count    <= '0;
         pass     <= 1'b0;
         err_idx  <= NO_ERR;
         ovf      <= 1'b0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         p1       <= p1_n;
         p2       <= p2_n;
         count    <= count_n;
         pass     <= pass_n;
         err_idx  <= err_idx_n;
         ovf      <= ovf_n;
         in_ready <= (state_n == T0) || (state_n == T1) || (state_n == CHECK);
         busy     <= (state_n != IDLE);
         done     <= (state_n == DONE);
      end
   end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Self-checking bench for fibonacci_checker: directed series plus random
// series with random valid gaps, checked against a plain-arithmetic model.
// Two instances: W=32/LEN=10 (a) and W=8/LEN=14 (b).
module tb_fibonacci_checker;

   logic clk = 1'b0;
   logic rst;

   logic        a_start, a_valid, a_rdy, a_busy, a_done, a_pass, a_ovf;
   logic [31:0] a_data;
   logic [7:0]  a_err, a_cnt;
   logic        b_start, b_valid, b_rdy, b_busy, b_done, b_pass, b_ovf;
   logic [7:0]  b_data;
   logic [7:0]  b_err, b_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int a_dcnt = 0;
   int b_dcnt = 0;

   always #5 clk = ~clk;

   fibonacci_checker #(.W(32), .LEN(10)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .in_valid(a_valid), .in_data(a_data),
      .in_ready(a_rdy), .busy(a_busy), .done(a_done), .pass(a_pass),
      .err_idx(a_err), .ovf(a_ovf), .count(a_cnt));

   fibonacci_checker #(.W(8), .LEN(14)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_data(b_data),
      .in_ready(b_rdy), .busy(b_busy), .done(b_done), .pass(b_pass),
      .err_idx(b_err), .ovf(b_ovf), .count(b_cnt));

   // Count cycles in which each done output is high.
   always @(posedge clk) begin
      if (a_done === 1'b1) a_dcnt++;
      if (b_done === 1'b1) b_dcnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: each term from index 2 must equal the true sum of the two
   // received terms before it; a sum that does not fit in w bits is overflow.
   task automatic model(input longint t[$], input int w,
                        output bit ep, output int ei, output bit eo);
      longint s;
      bit bad;
      ep = 1'b1; ei = 255; eo = 1'b0;
      for (int i = 0; i < t.size(); i++) begin
         if (i < 2) begin
`ifdef FIB_CHK_SEED_EN
            bad = 1'b0;
`else
            bad = (t[i] != 1);
`endif
         end else begin
            s = t[i-1] + t[i-2];
            if (s >= (64'sd1 << w)) begin
               eo = 1'b1;
               bad = 1'b1;
            end else begin
               bad = (s != t[i]);
            end
         end
         if (bad) begin
            ep = 1'b0;
            if (ei == 255) ei = i;
         end
      end
   endtask

   task automatic drive(input bit which, input logic st, input logic v, input longint d);
      if (which) begin
         b_start = st; b_valid = v; b_data = 8'(d);
      end else begin
         a_start = st; a_valid = v; a_data = 32'(d);
      end
   endtask

   task automatic sample(input bit which, output logic rdy, output logic bsy, output logic dn,
                         output logic ps, output logic [7:0] ei, output logic ov,
                         output logic [7:0] cn);
      if (which) begin
         rdy = b_rdy; bsy = b_busy; dn = b_done; ps = b_pass; ei = b_err; ov = b_ovf; cn = b_cnt;
      end else begin
         rdy = a_rdy; bsy = a_busy; dn = a_done; ps = a_pass; ei = a_err; ov = a_ovf; cn = a_cnt;
      end
   endtask

   // Start a series, stream it with random gaps, check the result window.
   task automatic run_series(input bit which, input longint t[$], input int gap_pct,
                             input string tag);
      bit ep, eo;
      int ei, idx, budget, d0;
      logic v, rdy, bsy, dn, ps, ov;
      logic [7:0] e, c;
      model(t, which ? 8 : 32, ep, ei, eo);
      d0 = which ? b_dcnt : a_dcnt;
      @(negedge clk);
      drive(which, 1'b1, 1'b0, 0);
      @(negedge clk);
      drive(which, 1'b0, 1'b0, 0);
      sample(which, rdy, bsy, dn, ps, e, ov, c);
      check({tag, ".ready_after_start"}, 64'(rdy), 64'd1);
      idx = 0;
      budget = 0;
      while (idx < t.size() && budget < 400) begin
         v = ($urandom_range(99) >= gap_pct);
         drive(which, 1'b0, v, t[idx]);
         sample(which, rdy, bsy, dn, ps, e, ov, c);
         @(posedge clk);
         if (v && rdy) idx++;
         budget++;
         @(negedge clk);
      end
      check({tag, ".all_terms_taken"}, 64'(idx), 64'(t.size()));
      // Cycle after the last transfer: done pulse with final results.
      drive(which, 1'b1, 1'b0, 0);
      sample(which, rdy, bsy, dn, ps, e, ov, c);
      check({tag, ".done"}, 64'(dn), 64'd1);
      check({tag, ".ready_in_done"}, 64'(rdy), 64'd0);
      check({tag, ".pass"}, 64'(ps), 64'(ep));
      check({tag, ".err_idx"}, 64'(e), 64'(ei));
      check({tag, ".ovf"}, 64'(ov), 64'(eo));
      check({tag, ".count"}, 64'(c), 64'(t.size()));
      // start held during DONE must be ignored.
      @(negedge clk);
      drive(which, 1'b0, 1'b0, 0);
      sample(which, rdy, bsy, dn, ps, e, ov, c);
      check({tag, ".done_one_cycle"}, 64'(dn), 64'd0);
      check({tag, ".idle_after_done"}, 64'(bsy), 64'd0);
      check({tag, ".done_pulses"}, 64'((which ? b_dcnt : a_dcnt) - d0), 64'd1);
   endtask

   function automatic void gen_series(input int len, input int w, output longint t[$]);
      longint m;
      m = (64'sd1 << w) - 1;
      t = {};
      if ($urandom_range(3) == 0) begin
         t.push_back(longint'($urandom_range(5)));
         t.push_back(longint'($urandom_range(5)));
      end else begin
         t.push_back(1);
         t.push_back(1);
      end
      for (int i = 2; i < len; i++) begin
         longint nx;
         nx = (t[i-1] + t[i-2]) & m;
         if ($urandom_range(9) == 0) nx = (nx + 1) & m;
         t.push_back(nx);
      end
   endfunction

   initial begin
      longint q[$];
      int d0;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 0);
      drive(1'b1, 1'b0, 1'b0, 0);
      repeat (3) @(negedge clk);
      check("reset.ready", 64'(a_rdy), 64'd0);
      check("reset.busy", 64'(a_busy), 64'd0);
      check("reset.pass", 64'(a_pass), 64'd0);
      check("reset.err_idx", 64'(a_err), 64'hFF);
      check("reset.count", 64'(a_cnt), 64'd0);
      rst = 1'b0;

      // Valid held in IDLE without start is never accepted.
      drive(1'b0, 1'b0, 1'b1, 1);
      repeat (4) @(negedge clk);
      check("idle.no_accept_count", 64'(a_cnt), 64'd0);
      check("idle.no_ready", 64'(a_rdy), 64'd0);
      drive(1'b0, 1'b0, 1'b0, 0);

      q = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
      run_series(1'b0, q, 0, "basic");
      q = '{1, 1, 2, 3, 5, 9, 14, 23, 37, 60};
      run_series(1'b0, q, 0, "mismatch");
      q = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
      run_series(1'b0, q, 50, "gaps");
      q = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
      run_series(1'b1, q, 0, "overflow");
      q = '{2, 1, 3, 4, 7, 11, 18, 29, 47, 76};
      run_series(1'b0, q, 20, "seeds");

      // Reset after four transfers discards the series with no done.
      d0 = a_dcnt;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 1);
      repeat (4) @(negedge clk);
      check("rst_mid.count_before", 64'(a_cnt), 64'd4);
      rst = 1'b1;
      #1;
      check("rst_mid.busy", 64'(a_busy), 64'd0);
      check("rst_mid.ready", 64'(a_rdy), 64'd0);
      check("rst_mid.count", 64'(a_cnt), 64'd0);
      check("rst_mid.err_idx", 64'(a_err), 64'hFF);
      check("rst_mid.pass", 64'(a_pass), 64'd0);
      drive(1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid.no_done", 64'(a_dcnt - d0), 64'd0);
      q = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
      run_series(1'b0, q, 30, "after_rst");

      // Random series on both widths.
      for (int k = 0; k < 6; k++) begin
         gen_series(10, 32, q);
         run_series(1'b0, q, 30, $sformatf("rand_a%0d", k));
      end
      for (int k = 0; k < 4; k++) begin
         gen_series(14, 8, q);
         run_series(1'b1, q, 30, $sformatf("rand_b%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
